alu16_issue_wb: RTL and testbench
=================================

// Module: alu16_issue_wb
// PURPOSE
//  Upstream issue and downstream writeback stage for the 16-bit combinational ALU.
//  Accepts one 16-bit instruction per valid/ready handshake and reads operands from an internal 8x16 register file.
//  Decodes the instruction onto the ALU control pins, captures the ALU result, writes it back, and holds a C/Z/V flag register.
//  Multi-cycle, one instruction in flight. Fixed latency: 3 cycles from accept to done.
// PARAMETERS
//  DW      16  datapath width; must be 16 to match the ALU
//  NREG    8   register count; register index is log2(NREG)=3 bits
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  instr        in   16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [8:0] imm9 (LDI only)
//  instr_valid  in   1   instr is valid
//  instr_ready  out  1   stage can accept; high only in IDLE
//  done         out  1   1-cycle pulse in WB
//  err          out  1   1-cycle pulse with done when op is illegal
//  alu_a        out  16  ALU operand A (registered)
//  alu_b        out  16  ALU operand B (registered)
//  alu_addsub   out  1   1 = subtract
//  alu_fn       out  2   00 sum, 01 slt, 10 shift, 11 logic
//  alu_s        out  2   00 SRL, 01 SLL, 10 SAR
//  alu_lgc      out  2   00 AND, 01 OR, 10 XOR, 11 NOR
//  alu_out      in   16  ALU result
//  alu_cflag    in   1   ALU carry-out
//  flags        out  3   {C,Z,V} flag register
//  dbg_addr     in   3   register-file debug read address
//  dbg_data     out  16  combinational read of reg[dbg_addr]
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State = IDLE. All registers, alu_a/alu_b, flags, latched instruction = 0.
//   - ALU control outputs = 0. done = err = 0.
//   - Any reset mid-operation aborts the instruction; no writeback occurs.
//  FSM: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions.
//   - IDLE: instr_ready=1. When instr_valid=1, latch instr and go to READ. instr_valid in other states is ignored; the source holds it.
//   - READ: alu_a <= reg[rs1], alu_b <= reg[rs2]. Drive ALU controls from the latched op.
//   - EXEC: the ALU settles combinationally. Capture res <= alu_out and car <= alu_cflag.
//   - WB: write res to rd, update flags, pulse done (and err if illegal).
//  Latency: accept at edge N gives done high in the cycle after edge N+3. Throughput is 1 instruction per 4 cycles.
//  Opcodes (addsub, fn, s, lgc):
//   0 ADD(0,00)  1 SUB(1,00)  2 SLT(1,01)  3 SRL(-,10,00)  4 SLL(-,10,01)  5 SRA(-,10,10)
//   6 AND(-,11,-,00)  7 OR(..01)  8 XOR(..10)  9 NOR(..11)  A LDI  B-F illegal
//  Shifts use alu_b[3:0] as the shift amount.
//  LDI: bypasses the ALU. Writes {7'b0,imm9} to rd in WB. Flags unchanged.
//  Register file:
//   - reg[0] reads 0 always; writes to rd=0 are dropped but flags still update.
//   - rs1 == rs2 == rd is legal; reads precede the write.
//  Flags:
//   - ADD/SUB: C=car; Z=(res==0); V=(a15==b'15)&&(res15!=a15), where b' = alu_b for ADD and ~alu_b for SUB.
//   - SLT/shift/logic: Z updated only; C and V held.
//   - Illegal op: no register write, flags held, done=1, err=1.
//  Word arithmetic wraps modulo 2^16. No exceptions.
// STRUCTURE
//  alu_defs.vh holds the opcode localparams, the FSM state encodings (2-bit), and the fn/s/lgc field codes.
//  One sub-module: alu_regfile8x16 (2 async read ports + debug read port, 1 sync write port, async reset, r0=0).
//  The ALU is instantiated beside this block at the top level, not inside it.
// TESTING
//  1. Reset mid-EXEC:
//   - Stimulus: LDI r1,5 -> done; ADD r2,r1,r1; assert rst_n=0 during EXEC.
//   - Required: r1=r2=0, flags=000, instr_ready=1 right after release.
//  2. Carry, zero and overflow on ADD:
//   - Stimulus: LDI r1,0x1FF; reg forced to 0x7FFF via LDI+SLL/OR sequence; ADD r3,r1,r1 with r1=0x7FFF.
//   - Required: r3=0xFFFE, flags C=0 Z=0 V=1.
//  3. SUB to zero:
//   - Stimulus: SUB r4,r1,r1.
//   - Required: r4=0, Z=1, C=1, V=0.
//   - Stimulus: SLT r5,r0,r1 with r1=5.
//   - Required: r5=1, C and V unchanged.
//  4. Shifts:
//   - Stimulus: r1=0x8000, r2=4; SRA, SRL, SLL r1 by r2.
//   - Required: 0xF800, 0x0800, 0x0000 (Z=1 on SLL).
//  5. Illegal op and r0 writes:
//   - Stimulus: op=0xC.
//   - Required: err and done pulse together; registers and flags unchanged.
//   - Stimulus: ADD r0,r1,r1.
//   - Required: r0 reads 0.
//  6. Handshake:
//   - Stimulus: instr_valid held high continuously.
//   - Required: instr_ready high exactly 1 of every 4 cycles; done 3 cycles after each accept; no dropped or duplicated instruction.

Source files
------------

// File: rtl/alu16_issue_wb_pkg.sv
// Shared types, opcode/field codes and decode helpers for the ALU issue/writeback stage.
package alu16_issue_wb_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SLT = 4'h2;
  localparam logic [3:0] OP_SRL = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOR = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;

  localparam logic [1:0] FN_SUM   = 2'b00;
  localparam logic [1:0] FN_SLT   = 2'b01;
  localparam logic [1:0] FN_SHIFT = 2'b10;
  localparam logic [1:0] FN_LOGIC = 2'b11;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SAR = 2'b10;

  localparam logic [1:0] LG_AND = 2'b00;
  localparam logic [1:0] LG_OR  = 2'b01;
  localparam logic [1:0] LG_XOR = 2'b10;
  localparam logic [1:0] LG_NOR = 2'b11;

  typedef struct packed {
    logic       addsub;
    logic [1:0] fn;
    logic [1:0] s;
    logic [1:0] lgc;
  } alu_ctrl_t;

  typedef struct packed {
    alu_ctrl_t alu;
    logic      legal;
    logic      is_ldi;
    logic      upd_czv;
    logic      upd_z;
  } dec_t;

  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (op)
      OP_ADD: d.upd_czv = 1'b1;
      OP_SUB: begin d.alu.addsub = 1'b1; d.upd_czv = 1'b1; end
      OP_SLT: begin d.alu.addsub = 1'b1; d.alu.fn = FN_SLT; d.upd_z = 1'b1; end
      OP_SRL: begin d.alu.fn = FN_SHIFT; d.alu.s = SH_SRL; d.upd_z = 1'b1; end
      OP_SLL: begin d.alu.fn = FN_SHIFT; d.alu.s = SH_SLL; d.upd_z = 1'b1; end
      OP_SRA: begin d.alu.fn = FN_SHIFT; d.alu.s = SH_SAR; d.upd_z = 1'b1; end
      OP_AND: begin d.alu.fn = FN_LOGIC; d.alu.lgc = LG_AND; d.upd_z = 1'b1; end
      OP_OR:  begin d.alu.fn = FN_LOGIC; d.alu.lgc = LG_OR;  d.upd_z = 1'b1; end
      OP_XOR: begin d.alu.fn = FN_LOGIC; d.alu.lgc = LG_XOR; d.upd_z = 1'b1; end
      OP_NOR: begin d.alu.fn = FN_LOGIC; d.alu.lgc = LG_NOR; d.upd_z = 1'b1; end
      OP_LDI: d.is_ldi = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Two's-complement overflow; for subtraction the second operand is seen inverted.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb, input logic sub);
    logic bp;
    bp = sub ? ~b_msb : b_msb;
    return (a_msb == bp) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu16_issue_wb_if.sv
// Instruction issue handshake and completion status between a source and the issue stage.
interface alu16_issue_wb_if;
  import alu16_issue_wb_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               done;
  logic               err;

  modport master (output instr, instr_valid, input instr_ready, done, err);
  modport slave  (input instr, instr_valid, output instr_ready, done, err);
endinterface

// File: rtl/alu16_issue_wb_regfile.sv
// 8x16 register file: two async read ports plus a debug port, one sync write port, r0 hardwired to 0.
module alu_regfile8x16 #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd1_addr,
  output logic [DW-1:0] rd1_data,
  input  logic [AW-1:0] rd2_addr,
  output logic [DW-1:0] rd2_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd1_data = (rd1_addr == '0) ? '0 : mem_q[rd1_addr];
  assign rd2_data = (rd2_addr == '0) ? '0 : mem_q[rd2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu16_issue_wb.sv
// Issue/writeback stage for the external 16-bit ALU: IDLE -> READ -> EXEC -> WB, one instruction in flight.
module alu16_issue_wb
  import alu16_issue_wb_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu16_issue_wb_if.slave        issue,
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  output logic                   alu_addsub,
  output logic [1:0]             alu_fn,
  output logic [1:0]             alu_s,
  output logic [1:0]             alu_lgc,
  input  logic [DW-1:0]          alu_out,
  input  logic                   alu_cflag,
  output logic [2:0]             flags,
  input  logic [2:0]             dbg_addr,
  output logic [DW-1:0]          dbg_data
);

  localparam int AW = $clog2(NREG);

  state_e        state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  alu_ctrl_t     ctrl_q, ctrl_d;
  logic          car_q, car_d;
  logic [2:0]    flags_q, flags_d;
  logic          done_q, done_d, err_q, err_d;

  dec_t          dec;
  logic [AW-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [DW-1:0] rs1_data, rs2_data, wb_data;
  logic          rf_we;
  logic          res_zero;

  assign dec      = decode_op(instr_q[15:12]);
  assign rd_idx   = instr_q[11:9];
  assign rs1_idx  = instr_q[8:6];
  assign rs2_idx  = instr_q[5:3];
  assign res_zero = (res_q == '0);

  alu_regfile8x16 #(.DW(DW), .NREG(NREG)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd1_addr (rs1_idx),
    .rd1_data (rs1_data),
    .rd2_addr (rs2_idx),
    .rd2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .waddr    (rd_idx),
    .wdata    (wb_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      car_q   <= 1'b0;
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      car_q   <= car_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue.instr_valid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands and controls are registered at the end of READ, so the ALU sees a stable input for all of EXEC.
  always_comb begin
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    car_d   = car_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rf_we   = 1'b0;
    wb_data = dec.is_ldi ? {{(DW-9){1'b0}}, instr_q[8:0]} : res_q;
    case (state_q)
      ST_IDLE: if (issue.instr_valid) instr_d = issue.instr;
      ST_READ: begin
        a_d    = rs1_data;
        b_d    = rs2_data;
        ctrl_d = dec.alu;
      end
      ST_EXEC: begin
        res_d = alu_out;
        car_d = alu_cflag;
      end
      ST_WB: begin
        done_d = 1'b1;
        err_d  = ~dec.legal;
        rf_we  = dec.legal;
        if (dec.upd_czv)
          flags_d = {car_q, res_zero, add_ovf(a_q[DW-1], b_q[DW-1], res_q[DW-1], dec.alu.addsub)};
        else if (dec.upd_z)
          flags_d[1] = res_zero;
      end
      default: ;
    endcase
  end

  assign issue.instr_ready = (state_q == ST_IDLE);
  assign issue.done        = done_q;
  assign issue.err         = err_q;
  assign alu_a             = a_q;
  assign alu_b             = b_q;
  assign alu_addsub        = ctrl_q.addsub;
  assign alu_fn            = ctrl_q.fn;
  assign alu_s             = ctrl_q.s;
  assign alu_lgc           = ctrl_q.lgc;
  assign flags             = flags_q;

endmodule

// File: tb/tb_alu16_issue_wb.sv
// Bench for alu16_issue_wb: directed vector table, reset/handshake sequences, random stream vs ISA model.
module tb_alu16_issue_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a, alu_b, alu_out, dbg_data;
  logic        alu_addsub, alu_cflag;
  logic [1:0]  alu_fn, alu_s, alu_lgc;
  logic [2:0]  flags;
  logic [2:0]  dbg_addr = 3'd0;
  logic [16:0] sum17;

  int vectors = 0;
  int miscompares = 0;

  alu16_issue_wb_if issue ();

  alu16_issue_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_addsub (alu_addsub),
    .alu_fn     (alu_fn),
    .alu_s      (alu_s),
    .alu_lgc    (alu_lgc),
    .alu_out    (alu_out),
    .alu_cflag  (alu_cflag),
    .flags      (flags),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // Stand-in for the combinational ALU that sits beside the DUT.
  always_comb begin
    alu_out   = '0;
    alu_cflag = 1'b0;
    sum17     = '0;
    case (alu_fn)
      2'b00: begin
        sum17     = alu_addsub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1) : ({1'b0, alu_a} + {1'b0, alu_b});
        alu_out   = sum17[15:0];
        alu_cflag = sum17[16];
      end
      2'b01: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
      2'b10: case (alu_s)
        2'b00:   alu_out = alu_a >> alu_b[3:0];
        2'b01:   alu_out = alu_a << alu_b[3:0];
        2'b10:   alu_out = 16'($signed(alu_a) >>> alu_b[3:0]);
        default: alu_out = alu_a;
      endcase
      default: case (alu_lgc)
        2'b00:   alu_out = alu_a & alu_b;
        2'b01:   alu_out = alu_a | alu_b;
        2'b10:   alu_out = alu_a ^ alu_b;
        default: alu_out = ~(alu_a | alu_b);
      endcase
    endcase
  end

  // ISA-level reference state.
  int         mreg [8];
  logic [2:0] mflags;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    mflags = 3'b000;
  endtask

  task automatic model_apply(input logic [15:0] ins, output bit e);
    int op, rd, a, b, sa, sb, sh, res, full;
    bit c, z, v;
    logic [15:0] ta, tb16;
    op = int'(ins[15:12]);
    rd = int'(ins[11:9]);
    a  = mreg[ins[8:6]];
    b  = mreg[ins[5:3]];
    ta = a[15:0];
    tb16 = b[15:0];
    sa = $signed(ta);
    sb = $signed(tb16);
    sh = b % 16;
    c = mflags[2];
    v = mflags[0];
    e = 1'b0;
    res = 0;
    case (op)
      0: begin full = a + b; res = full & 'hFFFF; c = (full > 'hFFFF);
               v = ((sa + sb) > 32767) || ((sa + sb) < -32768); end
      1: begin res = (a - b) & 'hFFFF; c = (a >= b);
               v = ((sa - sb) > 32767) || ((sa - sb) < -32768); end
      2: res = (sa < sb) ? 1 : 0;
      3: res = a >> sh;
      4: res = (a << sh) & 'hFFFF;
      5: res = (sa >>> sh) & 'hFFFF;
      6: res = a & b;
      7: res = a | b;
      8: res = a ^ b;
      9: res = (~(a | b)) & 'hFFFF;
      10: res = int'(ins[8:0]);
      default: e = 1'b1;
    endcase
    z = (res == 0);
    if (!e && op != 10) mflags = (op <= 1) ? {c, z, v} : {mflags[2], z, mflags[0]};
    if (!e && rd != 0) mreg[rd] = res;
  endtask

  function automatic logic [15:0] rr(input logic [3:0] op, input int rd, input int rs1, input int rs2);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'hA, 3'(rd), 9'(imm)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input logic [15:0] ins, output logic e, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!issue.instr_ready && n < 16) begin @(negedge clk); n++; end
    issue.instr       = ins;
    issue.instr_valid = 1'b1;
    @(negedge clk);
    issue.instr_valid = 1'b0;
    lat = 0;
    while (!issue.done && lat < 12) begin @(negedge clk); lat++; end
    e = issue.err;
  endtask

  task automatic peek(input int a, output logic [15:0] v);
    dbg_addr = 3'(a);
    #1;
    v = dbg_data;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [15:0] val;
    logic [2:0]  fl;
    logic        er;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] ins, input logic [15:0] val, input logic [2:0] fl,
                     input logic er, input string nm);
    vec_t t;
    t.ins = ins; t.val = val; t.fl = fl; t.er = er; t.nm = nm;
    tbl.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    int lat, dcnt, rcnt, nxt;
    bit me;
    logic [15:0] v, ins;
    logic [15:0] prog [4];
    int acc [4];
    int didx [$];

    issue.instr = '0;
    issue.instr_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst/ready", issue.instr_ready, 1);
    chk("rst/done_err", {issue.done, issue.err}, 0);
    chk("rst/flags", flags, 0);
    chk("rst/alu_ab", {alu_a, alu_b}, 0);
    chk("rst/ctrl", {alu_addsub, alu_fn, alu_s, alu_lgc}, 0);
    peek(3, v);
    chk("rst/r3", v, 0);

    // {C,Z,V} flags
    add(ldi(1, 'h7F),      16'h007F, 3'b000, 0, "ldi_r1_7f");
    add(ldi(2, 8),         16'h0008, 3'b000, 0, "ldi_r2_8");
    add(rr(4'h4, 3, 1, 2), 16'h7F00, 3'b000, 0, "sll_7f00");
    add(ldi(4, 'hFF),      16'h00FF, 3'b000, 0, "ldi_r4_ff");
    add(rr(4'h7, 1, 3, 4), 16'h7FFF, 3'b000, 0, "or_7fff");
    add(rr(4'h0, 3, 1, 1), 16'hFFFE, 3'b001, 0, "add_ovf");
    add(rr(4'h1, 4, 1, 1), 16'h0000, 3'b110, 0, "sub_zero");
    add(ldi(1, 5),         16'h0005, 3'b110, 0, "ldi_r1_5");
    add(rr(4'h2, 5, 0, 1), 16'h0001, 3'b100, 0, "slt_0_5");
    add(ldi(1, 'h100),     16'h0100, 3'b100, 0, "ldi_r1_100");
    add(ldi(2, 7),         16'h0007, 3'b100, 0, "ldi_r2_7");
    add(rr(4'h4, 1, 1, 2), 16'h8000, 3'b100, 0, "sll_8000");
    add(ldi(2, 4),         16'h0004, 3'b100, 0, "ldi_r2_4");
    add(rr(4'h5, 6, 1, 2), 16'hF800, 3'b100, 0, "sra");
    add(rr(4'h3, 6, 1, 2), 16'h0800, 3'b100, 0, "srl");
    add(rr(4'h4, 6, 1, 2), 16'h0000, 3'b110, 0, "sll_zero");
    add({4'hC, 3'd6, 3'd1, 3'd2, 3'd0}, 16'h0000, 3'b110, 1, "illegal_c");
    add(rr(4'h0, 0, 1, 1), 16'h0000, 3'b111, 0, "add_r0");
    add(rr(4'h8, 7, 1, 2), 16'h8004, 3'b101, 0, "xor");
    add(rr(4'h6, 7, 1, 2), 16'h0000, 3'b111, 0, "and_zero");
    add(rr(4'h9, 7, 0, 0), 16'hFFFF, 3'b101, 0, "nor");
    add(rr(4'h1, 7, 2, 1), 16'h8004, 3'b001, 0, "sub_borrow_ovf");
    add(ldi(5, 'h1FF),     16'h01FF, 3'b001, 0, "ldi_keeps_flags");
    add({4'hF, 3'd5, 3'd5, 3'd5, 3'd0}, 16'h01FF, 3'b001, 1, "illegal_f");

    foreach (tbl[i]) begin
      model_apply(tbl[i].ins, me);
      run(tbl[i].ins, e, lat);
      chk({tbl[i].nm, "/lat"}, lat, 3);
      chk({tbl[i].nm, "/err"}, e, tbl[i].er);
      peek(int'(tbl[i].ins[11:9]), v);
      chk({tbl[i].nm, "/rd"}, v, tbl[i].val);
      chk({tbl[i].nm, "/flags"}, flags, tbl[i].fl);
    end

    // Reset during EXEC must abort the ADD and clear all architectural state.
    model_apply(ldi(1, 5), me);
    run(ldi(1, 5), e, lat);
    peek(1, v);
    chk("rstx/ldi_r1", v, 16'h0005);
    @(negedge clk);
    issue.instr = rr(4'h0, 2, 1, 1);
    issue.instr_valid = 1'b1;
    @(negedge clk);
    issue.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("rstx/ready", issue.instr_ready, 1);
    chk("rstx/flags", flags, 0);
    peek(1, v);
    chk("rstx/r1", v, 0);
    peek(2, v);
    chk("rstx/r2", v, 0);
    dcnt = 0;
    repeat (6) begin @(negedge clk); if (issue.done) dcnt++; end
    chk("rstx/no_done", dcnt, 0);

    // Back-to-back issue with instr_valid held high.
    prog[0] = ldi(1, 3);
    prog[1] = ldi(2, 4);
    prog[2] = rr(4'h0, 3, 1, 2);
    prog[3] = rr(4'h1, 4, 3, 1);
    nxt = 0; rcnt = 0;
    @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      if (nxt < 4) begin issue.instr = prog[nxt]; issue.instr_valid = 1'b1; end
      else issue.instr_valid = 1'b0;
      if (issue.done) didx.push_back(c);
      if (c < 16 && issue.instr_ready) rcnt++;
      if (issue.instr_ready && issue.instr_valid) begin
        acc[nxt] = c;
        model_apply(prog[nxt], me);
        nxt++;
      end
      @(negedge clk);
    end
    chk("hs/ready_1_in_4", rcnt, 4);
    chk("hs/accepted", nxt, 4);
    chk("hs/done_count", didx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("hs/accept_cycle", acc[i], 4 * i);
      if (i < didx.size()) chk("hs/done_cycle", didx[i], acc[i] + 4);
    end
    peek(3, v);
    chk("hs/r3", v, 16'h0007);
    peek(4, v);
    chk("hs/r4", v, 16'h0004);
    chk("hs/flags", flags, 3'b100);

    // Random instruction stream against the ISA model.
    for (int k = 0; k < 60; k++) begin
      ins = 16'($urandom);
      model_apply(ins, me);
      run(ins, e, lat);
      chk("rnd/lat", lat, 3);
      chk("rnd/err", e, me);
      peek(int'(ins[11:9]), v);
      chk("rnd/rd", v, 32'(mreg[ins[11:9]]));
      chk("rnd/flags", flags, mflags);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
